// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer trigger stage: FSM encoding, LFSR constants and
// the elaboration-time parameter legality check.
package reaction_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRun,
    StDone,
    StFault
  } state_e;

  localparam int unsigned LfsrW = 14;
  // Feedback taps 14,5,3,1 expressed as bit positions 13,4,2,0.
  localparam logic [LfsrW-1:0] LfsrTaps = 14'h2015;
  localparam logic [LfsrW-1:0] LfsrSeed = 14'h0001;

  // The largest delay must fit in the counter, and the random part cannot exceed the LFSR.
  function automatic bit params_legal(input int unsigned delay_w, input int unsigned min_delay,
                                      input int unsigned rand_bits);
    longint max_delay;
    longint limit;
    max_delay = longint'(min_delay) + (longint'(1) << rand_bits) - 1;
    limit     = longint'(1) << delay_w;
    return (rand_bits <= LfsrW) && (rand_bits >= 1) && (max_delay < limit);
  endfunction

endpackage

// File: rtl/lfsr14.sv
// Free-running 14-bit maximal-length Fibonacci LFSR; steps every cycle, seeded on reset.
module lfsr14
  import reaction_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  output logic [LfsrW-1:0] q
);

  logic [LfsrW-1:0] q_q;
  logic [LfsrW-1:0] q_d;

  always_comb begin
    q_d = {q_q[LfsrW-2:0], ^(q_q & LfsrTaps)};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= LfsrSeed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reaction_trigger.sv
// Stimulus/trigger stage: random pre-stimulus delay, start/stop pulses for the elapsed-time
// counter, and false-start detection.
module reaction_trigger
  import reaction_pkg::*;
#(
  parameter int unsigned DELAY_W   = 12,
  parameter int unsigned MIN_DELAY = 500,
  parameter int unsigned RAND_BITS = 11
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               arm,
  input  logic               react,
  output logic               start,
  output logic               stop,
  output logic               led_on,
  output logic               busy,
  output logic               fault,
  output logic [DELAY_W-1:0] delay_ticks
);

  if (!params_legal(DELAY_W, MIN_DELAY, RAND_BITS)) begin : g_param_check
    $error("reaction_trigger: illegal DELAY_W / MIN_DELAY / RAND_BITS combination");
  end

  logic [LfsrW-1:0] lfsr;
  logic             unused_lfsr;

  lfsr14 u_lfsr (
    .clock(clock),
    .reset(reset),
    .q    (lfsr)
  );

  assign unused_lfsr = ^lfsr;

  state_e             state_q, state_d;
  logic               arm_q, react_q;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               fault_q, fault_d;
  logic               arm_rise, react_rise;
  logic [DELAY_W-1:0] new_delay;

  assign arm_rise   = arm & ~arm_q;
  assign react_rise = react & ~react_q;
  assign new_delay  = DELAY_W'(MIN_DELAY) + DELAY_W'(lfsr[RAND_BITS-1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    led_d   = led_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle, StDone, StFault: begin
        // Arm wins over a simultaneous react rise here.
        if (arm_rise) begin
          cnt_d   = new_delay;
          delay_d = new_delay;
          fault_d = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (react_rise) begin
          fault_d = 1'b1;
          state_d = StFault;
        end else if (tick) begin
          if (cnt_q <= DELAY_W'(1)) begin
            cnt_d   = '0;
            start_d = 1'b1;
            led_d   = 1'b1;
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - DELAY_W'(1);
          end
        end
      end
      StRun: begin
        if (react_rise) begin
          stop_d  = 1'b1;
          led_d   = 1'b0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StWait) || (state_d == StRun);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      // Reset high so a key held through reset is not seen as a press.
      arm_q   <= 1'b1;
      react_q <= 1'b1;
      cnt_q   <= '0;
      delay_q <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm;
      react_q <= react;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign start       = start_q;
  assign stop        = stop_q;
  assign led_on      = led_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign delay_ticks = delay_q;

endmodule

// File: tb/tb_reaction_trigger.sv
// Scoreboard bench for reaction_trigger: stimulus queues expected output vectors with their
// cycle stamps, a monitor pops one on every change of the DUT output vector.
module tb_reaction_trigger;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       arm = 1'b1;
  logic       react = 1'b0;
  logic       start, stop, led_on, busy, fault;
  logic [3:0] delay_ticks;

  always #5 clock = ~clock;

  reaction_trigger #(
    .DELAY_W  (4),
    .MIN_DELAY(4),
    .RAND_BITS(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .arm        (arm),
    .react      (react),
    .start      (start),
    .stop       (stop),
    .led_on     (led_on),
    .busy       (busy),
    .fault      (fault),
    .delay_ticks(delay_ticks)
  );

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       led;
    logic       busy;
    logic       fault;
    logic [3:0] delay;
  } outs_t;

  typedef struct packed {
    int    cyc;
    outs_t o;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic [13:0] m;
  logic        arm_lvl = 1'b1;
  logic        react_lvl = 1'b0;
  outs_t       cur;
  outs_t       prev = '0;
  exp_t        e;

  function automatic logic [13:0] lfsr_step(input logic [13:0] v);
    return {v[12:0], v[13] ^ v[4] ^ v[2] ^ v[0]};
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    m   <= reset ? 14'h0001 : lfsr_step(m);
  end

  task automatic check(input string name, input logic ok, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic expect_at(input int c, input logic s, input logic p, input logic l,
                           input logic b, input logic f, input logic [3:0] d);
    exp_t x;
    x.cyc = c;
    x.o   = {s, p, l, b, f, d};
    sb.push_back(x);
  endtask

  // Monitor: every change of the output vector must match the next queued expectation.
  always @(negedge clock) begin
    cur = {start, stop, led_on, busy, fault, delay_ticks};
    if (mon_en && (cur !== prev)) begin
      check($sformatf("spurious_output@%0d", cyc), sb.size() != 0, 32'(cur), 32'(prev));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("outputs@%0d", e.cyc), e.o === cur, 32'(cur), 32'(e.o));
        check($sformatf("event_cycle@%0d", e.cyc), e.cyc == cyc, 32'(cyc), 32'(e.cyc));
      end
      if (cur.busy && !prev.busy)
        check("delay_range", (cur.delay >= 4'd4) && (cur.delay <= 4'd7), 32'(cur.delay), 32'd4);
    end
    prev = cur;
  end

  task automatic drive(input logic r, input logic a, input logic k, input logic t);
    reset = r;
    arm   = a;
    react = k;
    tick  = t;
    @(negedge clock);
  endtask

  task automatic idle_cyc();
    drive(1'b0, arm_lvl, react_lvl, 1'b0);
  endtask

  task automatic wait_ticks(input int n, input bit wiggle);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (wiggle) arm_lvl = ~arm_lvl;
        drive(1'b0, arm_lvl, react_lvl, j == 2);
      end
    end
  endtask

  task automatic arm_trial(input logic with_react, output logic [3:0] d);
    arm_lvl = 1'b0;
    idle_cyc();
    d = 4'd4 + 4'(m[1:0]);
    expect_at(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, d);
    arm_lvl = 1'b1;
    if (with_react) react_lvl = 1'b1;
    idle_cyc();
  endtask

  task automatic run_to_start(input logic [3:0] d, input bit wiggle);
    wait_ticks(int'(d) - 1, wiggle);
    idle_cyc();
    idle_cyc();
    expect_at(cyc + 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, d);
    expect_at(cyc + 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, d);
    drive(1'b0, arm_lvl, react_lvl, 1'b1);
    idle_cyc();
  endtask

  task automatic react_stop(input logic [3:0] d);
    react_lvl = 1'b0;
    idle_cyc();
    expect_at(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, d);
    expect_at(cyc + 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, d);
    react_lvl = 1'b1;
    idle_cyc();
    react_lvl = 1'b0;
    idle_cyc();
  endtask

  initial begin
    logic [3:0] d;
    bit         saw_zero;
    bit         early_wrap;

    // Reset with arm held, then LFSR free-run with arm still held (must stay idle).
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("reset_outputs", {start, stop, led_on, busy, fault, delay_ticks} === 9'd0,
          32'({start, stop, led_on, busy, fault, delay_ticks}), 32'd0);
    check("lfsr_seed", dut.u_lfsr.q === 14'h0001, 32'(dut.u_lfsr.q), 32'h1);
    mon_en     = 1'b1;
    saw_zero   = 1'b0;
    early_wrap = 1'b0;
    for (int i = 1; i <= 16383; i++) begin
      drive(1'b0, 1'b1, 1'b0, (i % 3) == 0);
      if (dut.u_lfsr.q == 14'h0) saw_zero = 1'b1;
      if ((i < 16383) && (dut.u_lfsr.q == 14'h0001)) early_wrap = 1'b1;
    end
    check("lfsr_never_zero", !saw_zero, 32'(saw_zero), 32'd0);
    check("lfsr_no_short_period", !early_wrap, 32'(early_wrap), 32'd0);
    check("lfsr_period", dut.u_lfsr.q === 14'h0001, 32'(dut.u_lfsr.q), 32'h1);
    check("held_arm_idle", busy === 1'b0, 32'(busy), 32'd0);

    // Normal trial, react 5 ticks after start.
    arm_trial(1'b0, d);
    run_to_start(d, 1'b0);
    wait_ticks(5, 1'b0);
    react_stop(d);

    // False start on the second tick of WAIT.
    arm_trial(1'b0, d);
    wait_ticks(1, 1'b0);
    idle_cyc();
    idle_cyc();
    expect_at(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d);
    react_lvl = 1'b1;
    drive(1'b0, arm_lvl, 1'b1, 1'b1);
    react_lvl = 1'b0;
    wait_ticks(int'(d), 1'b0);
    check("false_start_led", led_on === 1'b0, 32'(led_on), 32'd0);
    check("false_start_fault", fault === 1'b1, 32'(fault), 32'd1);

    // Arm clears fault; arm toggled throughout WAIT and RUN must be ignored.
    arm_trial(1'b0, d);
    run_to_start(d, 1'b1);
    wait_ticks(2, 1'b1);
    react_stop(d);

    // React on the final tick: fault wins, no start.
    arm_trial(1'b0, d);
    wait_ticks(int'(d) - 1, 1'b0);
    idle_cyc();
    idle_cyc();
    expect_at(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d);
    react_lvl = 1'b1;
    drive(1'b0, arm_lvl, 1'b1, 1'b1);
    react_lvl = 1'b0;
    wait_ticks(2, 1'b0);

    // Reach DONE, then arm and react rise together: arm taken.
    arm_trial(1'b0, d);
    run_to_start(d, 1'b0);
    react_stop(d);
    arm_trial(1'b1, d);
    run_to_start(d, 1'b0);
    react_stop(d);

    // Reset mid-RUN: everything clears, no stop pulse; next delay follows the seed sequence.
    arm_trial(1'b0, d);
    run_to_start(d, 1'b0);
    wait_ticks(1, 1'b0);
    expect_at(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, arm_lvl, 1'b0, 1'b0);
    arm_lvl = 1'b0;
    idle_cyc();
    // LFSR went 1 -> 3 since reset, so the capture is 4 + 3.
    expect_at(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
    arm_lvl = 1'b1;
    idle_cyc();
    run_to_start(4'd7, 1'b0);
    react_stop(4'd7);
    repeat (4) idle_cyc();

    check("scoreboard_drained", sb.size() == 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reaction_trigger.md
# reaction_trigger

Stimulus/trigger stage of the reaction-timer datapath: it sits directly upstream of the 16-bit elapsed-time counter and generates that counter's `start` and `stop` controls. On an arm request it waits a pseudo-random number of millisecond ticks, then lights the stimulus LED and pulses `start`. It pulses `stop` on the player's response, and flags a false start if the response arrives before the stimulus.

## Interface
- `DELAY_W`, default 12: width of the delay down-counter and of `delay_ticks`.
- `MIN_DELAY`, default 500: fixed part of the delay, in ticks.
- `RAND_BITS`, default 11: number of LFSR low bits added to `MIN_DELAY`. Legal only if `MIN_DELAY + 2^RAND_BITS - 1 < 2^DELAY_W` and `RAND_BITS <= 14`.
- `clock`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `tick`, in, 1: one-cycle enable, nominally 1 ms.
- `arm`, in, 1: arm key level, already synchronised and debounced.
- `react`, in, 1: response key level, already synchronised and debounced.
- `start`, out, 1: one-cycle pulse to the downstream counter.
- `stop`, out, 1: one-cycle pulse to the downstream counter.
- `led_on`, out, 1: stimulus LED.
- `busy`, out, 1: high in WAIT and RUN.
- `fault`, out, 1: false-start flag.
- `delay_ticks`, out, `DELAY_W`: delay captured for the current trial; held until the next arm.

## Operation
- Edge detection: `arm_q` and `react_q` register the inputs.
  - Rising edge is defined as `x & ~x_q`.
  - Both registers reset to 1, so a key held through reset does not trigger.
- LFSR: 14-bit Fibonacci, taps 14,5,3,1, maximal length.
  - Steps every cycle, independent of state.
  - Seed 14'h0001 on reset; never reaches zero.
- States: IDLE, WAIT, RUN, DONE, FAULT.
- IDLE, DONE and FAULT behave identically on an arm rise:
  - capture `MIN_DELAY + lfsr[RAND_BITS-1:0]` into the down-counter and `delay_ticks`;
  - clear `fault`;
  - go to WAIT.
- WAIT:
  - Each `tick` decrements the counter.
  - A tick that takes the counter from 1 to 0 moves to RUN, asserts `start` for one cycle and sets `led_on`.
  - A react rise moves to FAULT: set `fault`, `led_on` stays 0, no `start`.
  - If a react rise and the final tick coincide, react wins (FAULT).
  - Arm rises are ignored.
- RUN:
  - A react rise asserts `stop` for one cycle, clears `led_on` and moves to DONE.
  - Arm rises are ignored; there is no timeout.
- DONE and FAULT: idle until the next arm rise.
- Arm rise and react rise in the same cycle while in IDLE/DONE/FAULT: arm is taken, react is ignored.
- Reset at any time, mid-trial included: state IDLE, `start`=`stop`=`led_on`=`busy`=`fault`=0, `delay_ticks`=0, counter=0, LFSR=1.
  - No `stop` pulse is emitted for an aborted RUN.

## Timing
- All outputs are registered.
- If an arm rise is detected at edge k, `busy` and `delay_ticks` are valid after edge k.
- With N = `delay_ticks`, `start` and `led_on` rise after the edge that samples the N-th tick. `start` falls one cycle later; `led_on` stays high.
- If a react rise is detected at edge k in RUN, `stop` is high for the cycle after edge k and `led_on` falls together with `stop`.
- Ticks arriving in any state other than WAIT have no effect.
- Minimum delay is `MIN_DELAY` ticks; maximum is `MIN_DELAY + 2^RAND_BITS - 1`.

## Structure
- Package `reaction_pkg` holds:
  - the state encoding;
  - LFSR width (14), taps and seed;
  - the legal-parameter check as a constant function.
- One sub-module, `lfsr14`, with ports clock, reset and `q[13:0]`; instantiated once.
- The FSM, edge detectors and down-counter live in `reaction_trigger`.

## Test plan
All scenarios use `MIN_DELAY`=4, `RAND_BITS`=2, `DELAY_W`=4 and a tick every 3 clocks.
- Normal trial: arm rise → `busy`=1 and `delay_ticks` equals 4 plus the LFSR low 2 bits at that edge. `start` is a single pulse after exactly `delay_ticks` ticks, with `led_on`=1. A react rise 5 ticks later → one `stop` pulse, `led_on`=0, `busy`=0.
- False start: react rise on the second tick of WAIT → `fault`=1, no `start` ever, `led_on` stays 0. The next arm rise clears `fault` and runs a normal trial.
- Coincidence: react rise in the same cycle as the final tick → FAULT with no `start`. Arm and react rising together in DONE → new WAIT, `fault`=0.
- Held keys: `arm`=1 through reset release → stays IDLE. Repeated arm rises during WAIT and RUN → ignored, `delay_ticks` unchanged.
- Reset mid-RUN: after `start`, assert `reset` for one cycle → all outputs 0, no `stop` pulse. A following arm rise captures a delay from LFSR seed 14'h0001 sequencing.
- LFSR: free-run 16383 cycles from reset → returns to 14'h0001, never reads 0. Captured delays always lie in the range 4..7.
